// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one 16-byte block as eight 16-bit words
// from main memory, strobing the data array per word and the tag array on the last.

module dff (
  output logic q,
  input  logic d,
  input  logic wen,
  input  logic clk,
  input  logic rst
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= 1'b0;
    else if (wen) q <= d;
  end
endmodule

module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic [15:0] memory_data,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        write_data_array,
  output logic        write_tag_array,
  output logic [15:0] memory_address
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        state_bit_q;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] base_q, base_d;
  logic        base_wen;

  // Data words flow straight to the cache; block offset bits are never used.
  logic unused_inputs;
  assign unused_inputs = ^{memory_data, miss_address[3:0]};

  assign state_q = state_t'(state_bit_q);

  dff u_state (
    .q   (state_bit_q),
    .d   (state_d),
    .wen (1'b1),
    .clk (clk),
    .rst (rst)
  );

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    dff u_cnt (
      .q   (cnt_q[i]),
      .d   (cnt_d[i]),
      .wen (1'b1),
      .clk (clk),
      .rst (rst)
    );
  end

  for (genvar i = 0; i < 12; i++) begin : g_base
    dff u_base (
      .q   (base_q[i]),
      .d   (base_d[i]),
      .wen (base_wen),
      .clk (clk),
      .rst (rst)
    );
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    base_d           = base_q;
    base_wen         = 1'b0;
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    memory_address   = 16'h0000;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d  = WAIT;
          cnt_d    = 3'd0;
          base_d   = miss_address[15:4];
          base_wen = 1'b1;
        end
      end
      WAIT: begin
        fsm_busy       = 1'b1;
        // Fill always starts at word 0; the counter never carries into base.
        memory_address = {base_q, cnt_q, 1'b0};
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          if (cnt_q == 3'd7) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
            cnt_d           = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: reset, spaced and full-rate fills,
// ignored miss while busy, asynchronous abort, back-to-back fills.

module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] memory_address;

  int vectors = 0;
  int miscompares = 0;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .memory_address    (memory_address)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic busy, input logic wda,
                         input logic wta, input logic [15:0] addr);
    chk({tag, ".busy"}, {15'd0, fsm_busy}, {15'd0, busy});
    chk({tag, ".wda"},  {15'd0, write_data_array}, {15'd0, wda});
    chk({tag, ".wta"},  {15'd0, write_tag_array}, {15'd0, wta});
    chk({tag, ".addr"}, memory_address, addr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = 16'h0000;
    memory_data = 16'h0000;
    memory_data_valid = 1'b0;
    tick();
    #1 chk_out("reset_hold", 1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    tick();
    #1 chk_out("after_reset", 1'b0, 1'b0, 1'b0, 16'h0000);

    // Valid pulse while idle produces nothing
    memory_data_valid = 1'b1;
    #1 chk_out("idle_valid", 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    memory_data_valid = 1'b0;
    #1 chk_out("idle_after_valid", 1'b0, 1'b0, 1'b0, 16'h0000);

    // Basic fill at 0xABCD, valid every 4 cycles, stray miss at 0x1234 mid-fill
    miss_detected = 1'b1;
    miss_address = 16'hABCD;
    tick();
    miss_detected = 1'b0;
    miss_address = 16'h0000;
    #1 chk_out("basic_start", 1'b1, 1'b0, 1'b0, 16'hABC0);
    for (int w = 0; w < 8; w++) begin
      for (int g = 0; g < 3; g++) begin
        if (w == 2 && g == 1) begin
          miss_detected = 1'b1;
          miss_address = 16'h1234;
        end
        #1 chk_out("basic_gap", 1'b1, 1'b0, 1'b0, 16'hABC0 + 16'(2 * w));
        tick();
        miss_detected = 1'b0;
      end
      memory_data_valid = 1'b1;
      memory_data = 16'h5000 + 16'(w);
      #1 chk_out("basic_word", 1'b1, 1'b1, (w == 7), 16'hABC0 + 16'(2 * w));
      tick();
      memory_data_valid = 1'b0;
    end
    #1 chk_out("basic_done", 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();

    // Full-rate fill at 0xFFFF; back-to-back miss at 0x1000 right after tag write
    miss_detected = 1'b1;
    miss_address = 16'hFFFF;
    tick();
    miss_detected = 1'b0;
    memory_data_valid = 1'b1;
    for (int w = 0; w < 8; w++) begin
      #1 chk_out("full_word", 1'b1, 1'b1, (w == 7), 16'hFFF0 + 16'(2 * w));
      tick();
    end
    memory_data_valid = 1'b0;
    miss_detected = 1'b1;
    miss_address = 16'h1000;
    #1 chk_out("full_done", 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    miss_detected = 1'b0;
    #1 chk_out("b2b_start", 1'b1, 1'b0, 1'b0, 16'h1000);
    memory_data_valid = 1'b1;
    for (int w = 0; w < 8; w++) begin
      #1 chk_out("b2b_word", 1'b1, 1'b1, (w == 7), 16'h1000 + 16'(2 * w));
      tick();
    end
    memory_data_valid = 1'b0;
    #1 chk_out("b2b_done", 1'b0, 1'b0, 1'b0, 16'h0000);

    // Reset mid-fill after 3 words aborts immediately
    miss_detected = 1'b1;
    miss_address = 16'h2228;
    tick();
    miss_detected = 1'b0;
    memory_data_valid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      #1 chk_out("abort_word", 1'b1, 1'b1, 1'b0, 16'h2220 + 16'(2 * w));
      tick();
    end
    #1 chk_out("abort_pre", 1'b1, 1'b1, 1'b0, 16'h2226);
    rst = 1'b1;
    #1 chk_out("abort_rst", 1'b0, 1'b0, 1'b0, 16'h0000);
    #1 rst = 1'b0;
    tick();
    #1 chk_out("abort_idle", 1'b0, 1'b0, 1'b0, 16'h0000);
    memory_data_valid = 1'b0;
    miss_detected = 1'b1;
    miss_address = 16'h5670;
    tick();
    miss_detected = 1'b0;
    #1 chk_out("restart_start", 1'b1, 1'b0, 1'b0, 16'h5670);
    memory_data_valid = 1'b1;
    for (int w = 0; w < 8; w++) begin
      #1 chk_out("restart_word", 1'b1, 1'b1, (w == 7), 16'h5670 + 16'(2 * w));
      tick();
    end
    memory_data_valid = 1'b0;
    #1 chk_out("restart_done", 1'b0, 1'b0, 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
